// File: rtl/spi_peripheral_multi_if.sv
// spi_peripheral_multi_if: SPI pins plus the sub-peripheral side of the SPI target front-end.
// The slave modport is the front-end's view. The master modport is the host/decoder side.
interface spi_peripheral_multi_if #(
  parameter int OPCODE_BITS       = 8,
  parameter int DATA_BITS         = 8,
  parameter int RESPONSE_CHANNELS = 3,
  parameter int COUNT_WIDTH       = 16
);
  logic                                   spi_select_in;
  logic                                   spi_clock_in;
  logic                                   spi_data_in;
  logic                                   spi_data_out;
  logic [OPCODE_BITS-1:0]                 opcode_out;
  logic                                   opcode_valid_out;
  logic [DATA_BITS-1:0]                   operand_out;
  logic                                   operand_valid_out;
  logic [COUNT_WIDTH-1:0]                 operand_count_out;
  logic [RESPONSE_CHANNELS*DATA_BITS-1:0] response_in;
  logic [RESPONSE_CHANNELS-1:0]           response_valid_in;
  logic                                   response_conflict_out;
  logic                                   transaction_done_out;

  modport slave (
    input  spi_select_in, spi_clock_in, spi_data_in, response_in, response_valid_in,
    output spi_data_out, opcode_out, opcode_valid_out, operand_out, operand_valid_out,
           operand_count_out, response_conflict_out, transaction_done_out
  );

  modport master (
    output spi_select_in, spi_clock_in, spi_data_in, response_in, response_valid_in,
    input  spi_data_out, opcode_out, opcode_valid_out, operand_out, operand_valid_out,
           operand_count_out, response_conflict_out, transaction_done_out
  );
endinterface

// File: rtl/spi_peripheral_multi.sv
// spi_peripheral_multi: SPI target front-end.
// It receives an opcode followed by a stream of operand words.
// For each operand word it returns one response word, taken from the lowest-index valid channel.
//
// state  | meaning
// IDLE   | select high; waiting for synchronised select to fall
// OPCODE | shifting in opcode bits MSB first; MISO held low
// DATA   | shifting operand words in and response words out, word after word
module spi_peripheral_multi #(
  parameter int OPCODE_BITS       = 8,
  parameter int DATA_BITS         = 8,
  parameter int RESPONSE_CHANNELS = 3,
  parameter int SYNC_STAGES       = 2,
  parameter int COUNT_WIDTH       = 16,
  parameter int SPI_MODE          = 0
) (
  input logic                   clock_in,
  input logic                   reset_n_in,
  spi_peripheral_multi_if.slave bus
);
  localparam int MAX_BITS   = (OPCODE_BITS > DATA_BITS) ? OPCODE_BITS : DATA_BITS;
  localparam int INDEX_BITS = $clog2(MAX_BITS);
  localparam logic CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA = (SPI_MODE & 1) != 0;
  localparam logic [INDEX_BITS-1:0] OPCODE_LAST = INDEX_BITS'(OPCODE_BITS - 1);
  localparam logic [INDEX_BITS-1:0] DATA_LAST   = INDEX_BITS'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, OPCODE, DATA} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] select_sync, clock_sync, data_sync;
  logic select_s, clock_s, data_s, select_d, clock_d;
  logic select_fall, leading_edge, trailing_edge, sample_edge, launch_edge;

  logic [INDEX_BITS-1:0] bit_index, bit_index_next;
  logic [MAX_BITS-2:0]   shift_in;
  logic [MAX_BITS-1:0]   shift_next;
  logic [DATA_BITS-1:0]  tx_shift;
  logic [DATA_BITS-1:0]  response_sel;
  logic                  multi_valid;

  logic start_txn, shift_in_en, capture_opcode, capture_word, load_tx, shift_tx, done_next;

  logic [OPCODE_BITS-1:0] opcode_reg;
  logic                   opcode_valid_reg;
  logic [DATA_BITS-1:0]   operand_reg;
  logic                   operand_valid_reg;
  logic [COUNT_WIDTH-1:0] operand_count;
  logic                   conflict_reg;
  logic                   done_reg;
  logic                   miso_reg;

  assign select_s = select_sync[SYNC_STAGES-1];
  assign clock_s  = clock_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

  // SPI pins through the synchroniser. Each delayed copy resets to its idle level, so no edge is seen after reset.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      select_sync <= '1;
      clock_sync  <= {SYNC_STAGES{CPOL}};
      data_sync   <= '0;
      select_d    <= 1'b1;
      clock_d     <= CPOL;
    end else begin
      select_sync <= {select_sync[SYNC_STAGES-2:0], bus.spi_select_in};
      clock_sync  <= {clock_sync[SYNC_STAGES-2:0], bus.spi_clock_in};
      data_sync   <= {data_sync[SYNC_STAGES-2:0], bus.spi_data_in};
      select_d    <= select_s;
      clock_d     <= clock_s;
    end
  end

  assign select_fall   = select_d && !select_s;
  assign leading_edge  = (clock_s != CPOL) && (clock_d == CPOL);
  assign trailing_edge = (clock_s == CPOL) && (clock_d != CPOL);
  assign sample_edge   = CPHA ? trailing_edge : leading_edge;
  assign launch_edge   = CPHA ? leading_edge : trailing_edge;
  assign shift_next    = {shift_in, data_s};

  // Choose the response from the lowest-index valid channel, and flag when more than one channel is valid.
  always_comb begin
    response_sel = '0;
    multi_valid  = 1'b0;
    for (int k = RESPONSE_CHANNELS - 1; k >= 0; k--) begin
      if (bus.response_valid_in[k]) begin
        response_sel = bus.response_in[k*DATA_BITS +: DATA_BITS];
      end
    end
    for (int k = 1; k < RESPONSE_CHANNELS; k++) begin
      if (bus.response_valid_in[k] && (bus.response_valid_in & ((RESPONSE_CHANNELS)'(1) << k) - 1'b1) != '0) begin
        multi_valid = 1'b1;
      end
    end
  end

  // State register and bit index.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= IDLE;
      bit_index <= '0;
    end else begin
      state     <= state_next;
      bit_index <= bit_index_next;
    end
  end

  // Next state and per-cycle control strobes. A select release wins over a sample edge in the same cycle.
  always_comb begin
    state_next     = state;
    bit_index_next = bit_index;
    start_txn      = 1'b0;
    shift_in_en    = 1'b0;
    capture_opcode = 1'b0;
    capture_word   = 1'b0;
    load_tx        = 1'b0;
    shift_tx       = 1'b0;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (select_fall) begin
          state_next     = OPCODE;
          start_txn      = 1'b1;
          bit_index_next = OPCODE_LAST;
        end
      end
      OPCODE: begin
        if (select_s) begin
          state_next = IDLE;
          done_next  = opcode_valid_reg;
        end else if (sample_edge) begin
          shift_in_en = 1'b1;
          if (bit_index == '0) begin
            capture_opcode = 1'b1;
            state_next     = DATA;
            bit_index_next = DATA_LAST;
          end else begin
            bit_index_next = bit_index - INDEX_BITS'(1);
          end
        end
      end
      DATA: begin
        if (select_s) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          if (sample_edge) begin
            shift_in_en = 1'b1;
            if (bit_index == '0) begin
              capture_word   = 1'b1;
              bit_index_next = DATA_LAST;
            end else begin
              bit_index_next = bit_index - INDEX_BITS'(1);
            end
          end
          // A launch edge while the index still points at the MSB is the word load point.
          if (launch_edge) begin
            if (bit_index == DATA_LAST) begin
              load_tx = 1'b1;
            end else begin
              shift_tx = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Receive shift register, captured opcode and operand, and the per-transaction status.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      shift_in          <= '0;
      opcode_reg        <= '0;
      opcode_valid_reg  <= 1'b0;
      operand_reg       <= '0;
      operand_valid_reg <= 1'b0;
      operand_count     <= '0;
      conflict_reg      <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      done_reg          <= done_next;
      operand_valid_reg <= capture_word;
      if (shift_in_en) begin
        shift_in <= shift_next[MAX_BITS-2:0];
      end
      if (capture_opcode) begin
        opcode_reg       <= shift_next[OPCODE_BITS-1:0];
        opcode_valid_reg <= 1'b1;
      end else if (state_next == IDLE) begin
        opcode_valid_reg <= 1'b0;
      end
      if (start_txn) begin
        operand_reg   <= '0;
        operand_count <= '0;
        conflict_reg  <= 1'b0;
      end else begin
        if (capture_word) begin
          operand_reg <= shift_next[DATA_BITS-1:0];
          if (!(&operand_count)) begin
            operand_count <= operand_count + COUNT_WIDTH'(1);
          end
        end
        if (load_tx && multi_valid) begin
          conflict_reg <= 1'b1;
        end
      end
    end
  end

  // Transmit path: MISO stays low until DATA, then sends the loaded response word MSB first.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tx_shift <= '0;
      miso_reg <= 1'b0;
    end else if (state != DATA) begin
      tx_shift <= '0;
      miso_reg <= 1'b0;
    end else if (load_tx) begin
      miso_reg <= response_sel[DATA_BITS-1];
      tx_shift <= {response_sel[DATA_BITS-2:0], 1'b0};
    end else if (shift_tx) begin
      miso_reg <= tx_shift[DATA_BITS-1];
      tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
    end
  end

  assign bus.spi_data_out          = miso_reg;
  assign bus.opcode_out            = opcode_reg;
  assign bus.opcode_valid_out      = opcode_valid_reg;
  assign bus.operand_out           = operand_reg;
  assign bus.operand_valid_out     = operand_valid_reg;
  assign bus.operand_count_out     = operand_count;
  assign bus.response_conflict_out = conflict_reg;
  assign bus.transaction_done_out  = done_reg;
endmodule

// File: tb/tb_spi_peripheral_multi.sv
// tb_spi_peripheral_multi: scoreboard bench for spi_peripheral_multi.
// Instances 0..3 run SPI modes 0..3. Instance 4 is mode 0 with a 2-bit saturating count.
// All instances share one host. Each bit is held across the whole SPI clock pulse, so it is valid for both CPHA settings.
`timescale 1ns/1ps
module tb_spi_peripheral_multi;
  localparam int NI = 5;
  localparam int H  = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b1, p = 1'b0, mosi = 1'b0;
  logic [23:0] resp = '0;
  logic [2:0]  rvalid = '0;

  always #5 clk = ~clk;

  logic [NI-1:0] ov, opv, done, conf, miso;
  logic [7:0]    opnd [NI];
  logic [7:0]    opc  [NI];
  logic [15:0]   cnt  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int MODE = (g == 4) ? 0 : g;
    localparam int CW   = (g == 4) ? 2 : 16;
    localparam logic CPOL = (MODE >= 2);
    spi_peripheral_multi_if #(.COUNT_WIDTH(CW)) bus_if ();
    spi_peripheral_multi #(.SPI_MODE(MODE), .COUNT_WIDTH(CW)) dut (
      .clock_in   (clk),
      .reset_n_in (rst_n),
      .bus        (bus_if.slave)
    );
    assign bus_if.spi_select_in     = sel;
    assign bus_if.spi_clock_in      = p ^ CPOL;
    assign bus_if.spi_data_in       = mosi;
    assign bus_if.response_in       = resp;
    assign bus_if.response_valid_in = rvalid;
    assign ov[g]   = bus_if.operand_valid_out;
    assign opv[g]  = bus_if.opcode_valid_out;
    assign done[g] = bus_if.transaction_done_out;
    assign conf[g] = bus_if.response_conflict_out;
    assign miso[g] = bus_if.spi_data_out;
    assign opnd[g] = bus_if.operand_out;
    assign opc[g]  = bus_if.opcode_out;
    assign cnt[g]  = 16'(bus_if.operand_count_out);
  end

  int checks = 0;
  int errors = 0;
  logic [23:0] word_q [NI][$];
  logic [7:0]  opc_q  [NI][$];
  logic        done_q [NI][$];
  logic [7:0]  miso_q [$];

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input int inst);
    checks++;
    errors++;
    $display("FAIL %s inst%0d: got an output event, expected none queued", name, inst);
  endtask

  // Event monitor: operand pulses, opcode capture and done pulses are each popped from their queue and compared.
  logic [NI-1:0] opv_d = '0;
  logic [23:0]   e_word;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          if (word_q[i].size() == 0) fail_unexpected("operand", i);
          else begin
            e_word = word_q[i].pop_front();
            check("operand", i, 32'(opnd[i]), 32'(e_word[7:0]));
            check("count", i, 32'(cnt[i]), 32'(e_word[23:8]));
          end
        end
        if (opv[i] && !opv_d[i]) begin
          if (opc_q[i].size() == 0) fail_unexpected("opcode", i);
          else check("opcode", i, 32'(opc[i]), 32'(opc_q[i].pop_front()));
        end
        if (done[i]) begin
          if (done_q[i].size() == 0) fail_unexpected("done", i);
          else check("done_conflict", i, 32'(conf[i]), 32'(done_q[i].pop_front()));
        end
      end
    end
    opv_d <= opv;
  end

  // MISO monitor for the mode-0 instance. The host samples on the leading edge.
  int         miso_bits = 0;
  logic [7:0] miso_rx = '0;
  always @(posedge p or posedge sel) begin
    if (sel) begin
      miso_bits = 0;
    end else begin
      miso_rx = {miso_rx[6:0], miso[0]};
      miso_bits++;
      if (miso_bits == 8) begin
        miso_bits = 0;
        if (miso_q.size() == 0) fail_unexpected("miso_word", 0);
        else check("miso_word", 0, 32'(miso_rx), 32'(miso_q.pop_front()));
      end
    end
  end

  int         nwords = 0;
  logic [7:0] miso_exp = '0;

  function automatic logic [15:0] exp_count(input int i, input int n);
    return (i == 4 && n > 3) ? 16'd3 : 16'(n);
  endfunction

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int b = 0; b < n; b++) begin
      mosi = v[7-b];
      #(H); p = 1'b1;
      #(H); p = 1'b0;
      #(H);
    end
  endtask

  task automatic start_txn(input logic [7:0] opcode);
    nwords = 0;
    for (int i = 0; i < NI; i++) opc_q[i].push_back(opcode);
    miso_q.push_back(8'h00);
    sel = 1'b0;
    send_bits(opcode, 8);
  endtask

  task automatic send_word(input logic [7:0] v);
    nwords++;
    for (int i = 0; i < NI; i++) word_q[i].push_back({exp_count(i, nwords), v});
    miso_q.push_back(miso_exp);
    send_bits(v, 8);
  endtask

  task automatic end_txn(input logic c);
    for (int i = 0; i < NI; i++) done_q[i].push_back(c);
    sel = 1'b1;
    #(3*H);
    for (int i = 0; i < NI; i++) begin
      check("idle_count", i, 32'(cnt[i]), 32'(exp_count(i, nwords)));
      check("idle_conflict", i, 32'(conf[i]), 32'(c));
      check("idle_opcode_valid", i, 32'(opv[i]), 32'(0));
    end
  endtask

  initial begin
    #1;
    check("reset_flags", 0, 32'({ov, opv, done, conf, miso}), 32'(0));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #(3*H);
    check("post_reset_flags", 0, 32'({ov, opv, done, conf, miso}), 32'(0));

    // Opcode 0xA5 and one operand 0x3C, with no channel valid.
    rvalid = 3'b000; resp = 24'h000000; miso_exp = 8'h00;
    start_txn(8'hA5);
    send_word(8'h3C);
    end_txn(1'b0);

    // Channel 1 valid with 0x5A: MISO returns 0x5A after an all-zero opcode phase.
    rvalid = 3'b010; resp = 24'h005A00; miso_exp = 8'h5A;
    start_txn(8'h12);
    send_word(8'h77);
    end_txn(1'b0);

    // Channels 0 and 2 both valid: the lowest index wins and the conflict flag is sticky.
    rvalid = 3'b101; resp = 24'h220011; miso_exp = 8'h11;
    start_txn(8'h33);
    send_word(8'h44);
    end_txn(1'b1);

    // Three operands. The next select assertion clears the conflict flag and the count.
    rvalid = 3'b000; resp = 24'h000000; miso_exp = 8'h00;
    start_txn(8'h5E);
    for (int i = 0; i < NI; i++) begin
      check("conflict_cleared", i, 32'(conf[i]), 32'(0));
      check("count_cleared", i, 32'(cnt[i]), 32'(0));
    end
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    end_txn(1'b0);

    // Second operand cut short after 4 bits: it is discarded.
    start_txn(8'h81);
    send_word(8'h96);
    send_bits(8'hF0, 4);
    end_txn(1'b0);

    // Five operands: the 2-bit counter saturates at 3.
    rvalid = 3'b100; resp = 24'hC30000; miso_exp = 8'hC3;
    start_txn(8'hE7);
    for (int w = 0; w < 5; w++) send_word(8'(8'h10 + w));
    end_txn(1'b0);

    // Reset asserted mid-word forces every output low at once.
    rvalid = 3'b000; resp = 24'h000000; miso_exp = 8'h00;
    start_txn(8'hC6);
    send_bits(8'hAA, 3);
    mosi = 1'b1;
    #(H); p = 1'b1;
    #(H/2);
    check("opcode_valid_before_reset", 0, 32'(opv), 32'({NI{1'b1}}));
    rst_n = 1'b0;
    #1;
    check("reset_mid_flags", 0, 32'({ov, opv, done, conf, miso}), 32'(0));
    for (int i = 0; i < NI; i++) begin
      check("reset_mid_opcode", i, 32'(opc[i]), 32'(0));
      check("reset_mid_count", i, 32'(cnt[i]), 32'(0));
      check("reset_mid_operand", i, 32'(opnd[i]), 32'(0));
    end
    #(H/2 - 1); p = 1'b0;
    #(H); sel = 1'b1;
    #(H); rst_n = 1'b1;
    #(3*H);

    // A normal transaction after the reset.
    start_txn(8'h0F);
    send_word(8'hF0);
    end_txn(1'b0);

    for (int i = 0; i < NI; i++) begin
      check("word_q_drained", i, 32'(word_q[i].size()), 32'(0));
      check("opc_q_drained", i, 32'(opc_q[i].size()), 32'(0));
      check("done_q_drained", i, 32'(done_q[i].size()), 32'(0));
    end
    check("miso_q_drained", 0, 32'(miso_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(400_000);
    $display("FAIL watchdog: got no end of run, expected finish before 400us");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_peripheral_multi.md
# spi_peripheral_multi

- SPI target front-end that recovers an opcode and a stream of operand words from the external SPI host.
- Returns one response word per operand word, chosen from N sub-peripheral response channels.
- Sits between the MCU-facing SPI pins and the sub-peripheral register decoders.
- Successor to the fixed 8-bit, 3-channel, mode-0 interface: widths, channel count, synchroniser depth and SPI mode are parameters; adds response conflict detection, a transaction-done strobe and a saturating operand count.

## Interface
- OPCODE_BITS, 8, opcode width in bits (≥1)
- DATA_BITS, 8, operand and response word width (≥2)
- RESPONSE_CHANNELS, 3, number of response channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per SPI input (≥2)
- COUNT_WIDTH, 16, operand counter width
- SPI_MODE, 0, SPI mode 0–3: CPOL = bit 1, CPHA = bit 0
- clock_in  in  1  system clock; one clock, all logic on its rising edge
- reset_n_in  in  1  asynchronous, active-low reset
- spi_select_in  in  1  chip select, active low
- spi_clock_in  in  1  SPI clock
- spi_data_in  in  1  host-to-target data (MOSI)
- spi_data_out  out  1  target-to-host data (MISO), registered
- opcode_out  out  OPCODE_BITS  captured opcode
- opcode_valid_out  out  1  level; high from opcode capture until select deasserts
- operand_out  out  DATA_BITS  last completed operand word
- operand_valid_out  out  1  one-cycle pulse per completed operand word
- operand_count_out  out  COUNT_WIDTH  completed operand words in this transaction; saturates at all-ones
- response_in  in  RESPONSE_CHANNELS*DATA_BITS  response words; channel k at [k*DATA_BITS +: DATA_BITS]
- response_valid_in  in  RESPONSE_CHANNELS  per-channel valid
- response_conflict_out  out  1  sticky per transaction; set when more than one channel is valid at a word load
- transaction_done_out  out  1  one-cycle pulse when select deasserts after the opcode was captured

## Operation
- **Synchroniser:** select, clock and data each pass through SYNC_STAGES flops. Edges are detected on the synchronised clock against a one-cycle-delayed copy.
- **Edge definitions:**
  - Leading edge: transition away from the CPOL idle level. Trailing edge: the opposite transition.
  - Sample edge: leading if CPHA=0, otherwise trailing. Launch edge: the other one.
- **States:**
  - IDLE: select high. Moves to OPCODE when synchronised select falls.
  - OPCODE: bit index runs OPCODE_BITS−1 down to 0, MSB first. On the final sample edge, opcode_out is updated and opcode_valid_out sets in the next cycle. Moves to DATA.
  - DATA: bit index runs DATA_BITS−1 down to 0 and wraps to DATA_BITS−1 indefinitely. Each final sample edge updates operand_out, pulses operand_valid_out and increments operand_count_out (saturating).
  - Any state → IDLE when synchronised select rises. transaction_done_out pulses if the state was DATA or opcode_valid_out was set.
- **Entry to OPCODE** (select assertion) clears operand_out, operand_count_out and response_conflict_out. These hold their values while in IDLE.
- **Partial words:** a word cut short by select deassertion is discarded; no pulse, count unchanged.
- **MISO:**
  - Held at 0 in IDLE and OPCODE.
  - Word load point: the launch edge that launches the MSB of each DATA word. For CPHA=0 this is the trailing edge after the last opcode or operand sample.
  - At the word load point the transmit shift register loads the lowest-index valid channel's response, or zero if no channel is valid. response_conflict_out sets if more than one channel is valid.
  - Each later launch edge shifts the next bit, MSB first, onto spi_data_out.

## Timing
- All outputs are 0 while reset_n_in is low, and immediately on its assertion (asynchronous).
- Reset release takes effect on the next clock_in edge in IDLE.
- Input-to-detection latency: SYNC_STAGES+1 cycles from a pin transition to the internal edge event.
- opcode_valid_out / operand_valid_out: asserted 1 cycle after the detected final sample edge.
- spi_data_out changes 1 cycle after the detected launch edge.
- SPI clock constraints:
  - Each clock phase must last ≥ SYNC_STAGES+4 clock_in cycles.
  - Select setup and hold to the first and last SPI edge: ≥ SYNC_STAGES+2 cycles.
- Sub-peripherals must present the response within 2 cycles of opcode_valid_out rising (first word) or of operand_valid_out (later words).
- Simultaneous events:
  - Select deassert in the same cycle as a final sample edge: deassert wins, the word is discarded.
  - Count at all-ones: stays all-ones, pulses continue.

## Test plan
- SPI_MODE=0, host sends opcode 0xA5 and operand 0x3C → opcode_out=0xA5, opcode_valid_out high, one operand_valid_out pulse with operand_out=0x3C, count=1, one transaction_done_out pulse after deassert.
- Mode 0, opcode 0x12, channel 1 valid with 0x5A → MISO carries 0x00 during the opcode, then 0x5A MSB first; response_conflict_out=0.
- Channels 0 (0x11) and 2 (0x22) both valid → MISO returns 0x11, response_conflict_out=1 until the next select assertion.
- SPI_MODE=3, opcode then operands 0x01, 0x02, 0x03 → three pulses carrying the matching values, count=3; the same outcome in modes 1 and 2.
- Select deasserted after 4 bits of the second operand → exactly one pulse, count=1, done pulse; reset_n_in low mid-word → all outputs 0 immediately.
- COUNT_WIDTH=2, five operand words → count reads 1, 2, 3, 3, 3; five pulses.
